// File: rtl/riscv_pkg.sv
// Shared types and default widths for the instruction-fetch path.
package riscv_pkg;

  localparam int PC_W_DEFAULT    = 32;
  localparam int INSTR_W_DEFAULT = 32;
  localparam int PC_STEP         = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory request/response and decode handshake bundle for fetch_ctrl.
interface fetch_ctrl_if import riscv_pkg::*; #(
  parameter int PC_WIDTH    = PC_W_DEFAULT,
  parameter int INSTR_WIDTH = INSTR_W_DEFAULT
) ();

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [INSTR_WIDTH-1:0] inst_data;
  logic [PC_WIDTH-1:0]    inst_pc;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

endinterface

// File: rtl/fetch_ctrl_timer.sv
// Clearable up-counter; done flags the cycle that completes TIMEOUT enabled cycles.
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // Saturates so a held-off timeout (redirect in DRAIN) still fires later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (clr)                 count <= '0;
    else if (en && count != MAX)  count <= count + 1'b1;
  end

  assign done = en && (count >= LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: steers the PC unit, issues one memory request
// per PC, hands fetched words to decode and handles redirects and timeouts.
module fetch_ctrl import riscv_pkg::*; #(
  parameter int PC_WIDTH    = PC_W_DEFAULT,
  parameter int INSTR_WIDTH = INSTR_W_DEFAULT,
  parameter int TIMEOUT     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                halt,
  input  logic [PC_WIDTH-1:0] pc_in,
  output logic                pc_go,
  output logic                pc_sel,
  output logic [PC_WIDTH-1:0] pc_branch,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  fetch_ctrl_if.master        bus,
  output logic                busy,
  output logic                timeout_err
);

  fetch_state_t           state, state_nxt;
  logic [PC_WIDTH-1:0]    inst_pc_q;
  logic [INSTR_WIDTH-1:0] inst_data_q;
  logic                   req_fire;
  logic                   data_ld;
  logic                   err_set;
  logic                   err_clr;
  logic                   tmr_en;
  logic                   tmr_clr;
  logic                   tmr_done;

  // Redirect gates the request so the PC unit never sees go and sel together.
  assign bus.imem_req_valid = (state == S_REQ) && !halt && !redirect_valid;
  assign bus.imem_addr      = pc_in;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign pc_go     = req_fire;
  assign pc_sel    = redirect_valid;
  assign pc_branch = redirect_valid ? redirect_target : '0;

  assign bus.inst_valid = (state == S_OUT) && !redirect_valid;
  assign bus.inst_data  = inst_data_q;
  assign bus.inst_pc    = inst_pc_q;
  assign busy           = (state != S_IDLE);

  assign tmr_en  = (state == S_WAIT) || (state == S_DRAIN);
  assign tmr_clr = !tmr_en || (state_nxt != state);

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .done (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    data_ld   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!redirect_valid && start) begin
          state_nxt = S_REQ;
          err_clr   = 1'b1;
        end
      end
      S_REQ: begin
        if (redirect_valid)  state_nxt = S_REQ;
        else if (halt)       state_nxt = S_IDLE;
        else if (req_fire)   state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_nxt = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (bus.imem_rsp_valid) begin
          state_nxt = S_OUT;
          data_ld   = 1'b1;
        end else if (tmr_done) begin
          state_nxt = S_IDLE;
          err_set   = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid || bus.inst_ready) state_nxt = S_REQ;
      end
      S_DRAIN: begin
        // The stale response is the only one outstanding, so it ends the drain.
        if (bus.imem_rsp_valid)  state_nxt = S_REQ;
        else if (redirect_valid) state_nxt = S_DRAIN;
        else if (tmr_done) begin
          state_nxt = S_IDLE;
          err_set   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      timeout_err <= 1'b0;
      inst_pc_q   <= '0;
      inst_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (err_set)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (req_fire)     inst_pc_q   <= pc_in;
      if (data_ld)      inst_data_q <= bus.imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a PC-unit model and a randomized memory.
module tb_fetch_ctrl;
  import riscv_pkg::*;

  localparam int PW = 32;
  localparam int IW = 32;
  localparam int TO = 16;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          halt;
  logic [PW-1:0] pc_in;
  logic          pc_go;
  logic          pc_sel;
  logic [PW-1:0] pc_branch;
  logic          redirect_valid;
  logic [PW-1:0] redirect_target;
  logic          busy;
  logic          timeout_err;

  fetch_ctrl_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

  fetch_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .halt            (halt),
    .pc_in           (pc_in),
    .pc_go           (pc_go),
    .pc_sel          (pc_sel),
    .pc_branch       (pc_branch),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .bus             (bus),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pops   = 0;
  logic [PW-1:0] last_pc = '0;
  logic [PW-1:0] next_pc = '0;
  exp_t exp_q[$];
  int   hs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // PC unit: single source of truth for the fetch address.
  logic [PW-1:0] pc_reg;
  always @(posedge clk or posedge rst) begin
    if (rst)         pc_reg <= '0;
    else if (pc_sel) pc_reg <= pc_branch;
    else if (pc_go)  pc_reg <= pc_reg + PW'(PC_STEP);
  end
  assign pc_in = pc_reg;

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_wait(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
  endtask

  // Memory model: one outstanding request, response 'dly' cycles after acceptance.
  bit            mem_on      = 1'b1;
  bit            mem_rdy_rnd = 1'b0;
  int            mem_dmin    = 1;
  int            mem_dmax    = 1;
  bit            acc;
  logic [PW-1:0] acc_addr;
  bit            pend = 1'b0;
  int            pend_cnt;
  logic [PW-1:0] pend_addr;

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acc      = bus.imem_req_valid && bus.imem_req_ready;
      acc_addr = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (acc && mem_on) begin
        pend      = 1'b1;
        pend_cnt  = $urandom_range(mem_dmax, mem_dmin);
        pend_addr = acc_addr;
      end
      if (pend) begin
        if (pend_cnt <= 1) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(pend_addr);
          pend               = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      bus.imem_req_ready = mem_rdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every decode handshake must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.inst_valid && bus.inst_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        fail_wait("unexpected_inst");
      end else begin
        e = exp_q.pop_front();
        chk("inst_pc", 64'(bus.inst_pc), 64'(e.pc));
        chk("inst_data", 64'(bus.inst_data), 64'(e.data));
        last_pc = e.pc;
        pops++;
      end
    end
    if (pc_go || pc_sel) chk("go_sel_exclusive", 64'(pc_go && pc_sel), 64'(0));
  end

  task automatic push_run(input logic [PW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{pc: base + PW'(4 * i), data: mem_word(base + PW'(4 * i))});
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget, input bit rnd, input string name);
    for (int i = 0; i < budget && pops < n; i++) begin
      @(posedge clk);
      #1;
      if (rnd) bus.inst_ready = 1'($urandom_range(0, 1));
    end
    if (pops < n) fail_wait(name);
  endtask

  task automatic wait_sig(input int which, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = pc_go;
        1:       hit = bus.inst_valid;
        default: hit = !busy;
      endcase
    end
    if (!hit) fail_wait(name);
  endtask

  task automatic end_phase(input string name);
    bus.inst_ready = 1'b1;
    halt           = 1'b1;
    wait_sig(2, 80, name);
    @(posedge clk);
    #1;
    halt = 1'b0;
    exp_q.delete();
    next_pc = last_pc + PW'(PC_STEP);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int a;
    int b;
    logic [PW-1:0] p;
    rst             = 1'b1;
    start           = 1'b0;
    halt            = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    bus.inst_ready  = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_timeout_err", 64'(timeout_err), 0);
    chk("rst_inst_valid", 64'(bus.inst_valid), 0);
    chk("rst_req_valid", 64'(bus.imem_req_valid), 0);
    chk("rst_pc_go", 64'(pc_go), 0);
    chk("rst_pc_sel", 64'(pc_sel), 0);
    chk("rst_pc_branch", 64'(pc_branch), 0);
    chk("rst_inst_pc", 64'(bus.inst_pc), 0);
    chk("rst_inst_data", 64'(bus.inst_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 0);
    @(posedge clk);
    #1;

    // Zero-wait memory, decode always ready: 0,4,8,... every 3 cycles
    bus.inst_ready = 1'b1;
    pops = 0;
    hs_cyc.delete();
    push_run(32'h0, 12);
    c0 = cyc;
    kick();
    wait_pops(6, 100, 1'b0, "zw_pops");
    if (hs_cyc.size() >= 5) begin
      chk("zw_first_latency", 64'(hs_cyc[0] - c0), 3);
      for (int i = 1; i < 5; i++) chk("zw_cadence", 64'(hs_cyc[i] - hs_cyc[i-1]), 3);
    end else begin
      fail_wait("zw_handshake_count");
    end
    end_phase("zw_idle");

    // Randomized memory latency/ready and decode backpressure
    mem_rdy_rnd = 1'b1;
    mem_dmin    = 1;
    mem_dmax    = 4;
    pops = 0;
    push_run(next_pc, 24);
    kick();
    wait_pops(16, 800, 1'b1, "rnd_pops");
    end_phase("rnd_idle");

    // Decode stall: output held, no new request, PC unit idle
    mem_rdy_rnd    = 1'b0;
    mem_dmin       = 1;
    mem_dmax       = 2;
    bus.inst_ready = 1'b0;
    pops = 0;
    p = next_pc;
    push_run(p, 1);
    kick();
    wait_sig(1, 40, "stall_valid");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_inst_valid", 64'(bus.inst_valid), 1);
      chk("stall_inst_pc", 64'(bus.inst_pc), 64'(p));
      chk("stall_inst_data", 64'(bus.inst_data), 64'(mem_word(p)));
      chk("stall_req_valid", 64'(bus.imem_req_valid), 0);
      chk("stall_pc_in", 64'(pc_in), 64'(p + PW'(PC_STEP)));
    end
    @(posedge clk);
    #1;
    end_phase("stall_idle");
    chk("stall_pops", 64'(pops), 1);
    chk("stall_pc_after", 64'(pc_in), 64'(next_pc));

    // Redirect while waiting for memory: stale response discarded
    mem_dmin = 3;
    mem_dmax = 3;
    bus.inst_ready = 1'b1;
    pops = 0;
    push_run(32'hDEADBEEC, 5);
    kick();
    wait_sig(0, 40, "rw_accept");
    @(posedge clk);
    #1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hDEADBEEC;
    @(negedge clk);
    chk("rw_pc_sel", 64'(pc_sel), 1);
    chk("rw_pc_branch", 64'(pc_branch), 64'(32'hDEADBEEC));
    chk("rw_pc_go", 64'(pc_go), 0);
    chk("rw_req_valid", 64'(bus.imem_req_valid), 0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    wait_pops(3, 200, 1'b0, "rw_pops");
    end_phase("rw_idle");

    // Redirect in OUT with decode ready the same cycle: instruction squashed
    mem_dmin       = 1;
    mem_dmax       = 3;
    bus.inst_ready = 1'b0;
    pops = 0;
    push_run(32'h0000_1000, 5);
    kick();
    wait_sig(1, 40, "ro_valid");
    @(posedge clk);
    #1;
    bus.inst_ready  = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_1000;
    @(negedge clk);
    chk("ro_inst_valid", 64'(bus.inst_valid), 0);
    chk("ro_pc_sel", 64'(pc_sel), 1);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    wait_pops(3, 200, 1'b0, "ro_pops");
    end_phase("ro_idle");

    // Memory never answers: sticky timeout, then start clears and resumes
    mem_on = 1'b0;
    pops = 0;
    kick();
    wait_sig(0, 40, "to_accept");
    a = cyc;
    wait_sig(2, 60, "to_idle");
    b = cyc;
    chk("to_latency", 64'(b - a), 64'(TO + 1));
    chk("to_err", 64'(timeout_err), 1);
    chk("to_busy", 64'(busy), 0);
    @(posedge clk);
    #1;
    mem_on = 1'b1;
    next_pc = next_pc + PW'(PC_STEP);
    push_run(next_pc, 6);
    kick();
    @(negedge clk);
    chk("to_err_cleared", 64'(timeout_err), 0);
    chk("to_busy_resume", 64'(busy), 1);
    wait_pops(3, 200, 1'b0, "to_pops");
    end_phase("to_idle2");

    // Reset during WAIT; the late response must be ignored
    mem_dmin = 4;
    mem_dmax = 4;
    pops = 0;
    kick();
    wait_sig(0, 40, "mr_accept");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_busy", 64'(busy), 0);
    chk("mr_inst_valid", 64'(bus.inst_valid), 0);
    chk("mr_req_valid", 64'(bus.imem_req_valid), 0);
    chk("mr_inst_pc", 64'(bus.inst_pc), 0);
    chk("mr_inst_data", 64'(bus.inst_data), 0);
    chk("mr_timeout_err", 64'(timeout_err), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mr_post_valid", 64'(bus.inst_valid), 0);
      chk("mr_post_busy", 64'(busy), 0);
      chk("mr_post_pc_go", 64'(pc_go), 0);
    end
    chk("mr_pops", 64'(pops), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer sitting between the program counter control unit, instruction memory and decode. It drives the PC unit's advance/branch-load controls, issues one instruction-memory request per PC, returns fetched words to decode over a valid/ready handshake, and handles redirects (branch/jump) and memory timeouts. The block holds no PC register of its own; the PC unit remains the single source of truth.

## Interface
- PC_WIDTH, 32, PC and address width
- INSTR_WIDTH, 32, instruction word width
- TIMEOUT, 16, max cycles waiting for a memory response before error (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin fetching (sampled in IDLE only)
- halt  in  1  stop before issuing next request
- pc_in  in  PC_WIDTH  current PC from PC unit
- pc_go  out  1  one-cycle pulse: PC unit advances by 4
- pc_sel  out  1  one-cycle pulse: PC unit loads pc_branch
- pc_branch  out  PC_WIDTH  branch target to PC unit
- redirect_valid  in  1  redirect request from execute
- redirect_target  in  PC_WIDTH  redirect address
- imem_req_valid  out  1  memory request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  PC_WIDTH  request address (= pc_in)
- imem_rsp_valid  in  1  response valid (≥1 cycle after acceptance)
- imem_rsp_data  in  INSTR_WIDTH  response word
- inst_valid  out  1  fetched instruction valid to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  INSTR_WIDTH  fetched word
- inst_pc  out  PC_WIDTH  address of inst_data
- busy  out  1  state ≠ IDLE
- timeout_err  out  1  sticky timeout flag

## Operation
- States: IDLE, REQ, WAIT, OUT, DRAIN.
- IDLE: start → REQ; start also clears timeout_err. start in any other state ignored.
- REQ: halt=1 → IDLE, no request. Else imem_req_valid=1, imem_addr=pc_in. On req_valid&req_ready: latch pc_in into inst_pc register, pulse pc_go, → WAIT.
- WAIT: imem_rsp_valid → latch inst_data, → OUT. Timer counts cycles in WAIT/DRAIN; reaching TIMEOUT → timeout_err=1, → IDLE.
- OUT: inst_valid=1; inst_data/inst_pc held stable until inst_ready. On handshake → REQ (halt then evaluated in REQ).
- DRAIN: discard next imem_rsp_valid, → REQ. Timeout as WAIT.
- Redirect (any state, including IDLE) has priority: pc_sel=1, pc_branch=redirect_target, pc_go forced 0, imem_req_valid forced 0 (combinational gate) that cycle. Next state: IDLE→IDLE, REQ→REQ, WAIT→DRAIN, DRAIN→DRAIN, OUT→REQ (inst_valid dropped, instruction squashed even if inst_ready=1 same cycle).
- Redirect and rsp_valid same cycle in WAIT: response discarded, → REQ (not DRAIN).
- Timer cleared on entry to WAIT/DRAIN; width $clog2(TIMEOUT+1).

## Timing
- Reset: state IDLE; pc_go, pc_sel, imem_req_valid, inst_valid, busy, timeout_err = 0; pc_branch, imem_addr-latch, inst_data, inst_pc = 0. Reset mid-fetch abandons outstanding response; later responses ignored in IDLE.
- pc_sel at cycle N → pc_in = target at N+1; REQ at N+1 uses it. pc_go at N → pc_in+4 at N+1.
- Zero-wait memory: start cycle 0, REQ/accept 1, rsp 2, inst_valid 3. Steady state one instruction per 3 cycles with inst_ready=1.
- pc_go, pc_sel never both 1. Outputs other than gated req_valid/pc_sel/pc_branch are registered or state-decoded.

## Structure
- riscv_pkg: fetch_state_t enum, PC_WIDTH/INSTR_WIDTH defaults, PC_STEP=4.
- Sub-module fetch_timer: clearable up-counter with terminal-count flag, parameter TIMEOUT.

## Test plan
- Reset then start with memory always ready, 1-cycle response, inst_ready=1 → inst_pc 0,4,8,… every 3 cycles; inst_data matches memory model.
- inst_ready low 5 cycles in OUT → inst_valid, inst_data, inst_pc stable; no new imem request; PC unit unchanged.
- Redirect to 0xDEADBEEC during WAIT → pc_sel pulse, state DRAIN, first response discarded, next inst_pc = 0xDEADBEEC.
- Redirect in OUT with inst_ready=1 same cycle → instruction squashed, next inst_pc = target.
- No response for TIMEOUT=16 cycles → timeout_err=1, busy=0; start clears flag and resumes.
- Assert rst mid-WAIT, deliver response after release → no inst_valid, all outputs at reset values.
